multi_push_queue: RTL
=====================

Name: multi_push_queue

Overview:
- Compacting queue that accepts up to Lanes pushes per cycle and removes any subset of valid entries per cycle by per-entry pop mask.
- Survivors are compacted toward index 0, preserving their order; new entries are appended behind them.
- Adds flush, lane-ordered backpressure, post-pop slot reuse and status flags.
- Sits between multi-issue producers and an out-of-order consumer that retires arbitrary entries.

Parameters:
- Size, 16, number of entries; Size >= 2.
- Lanes, 2, number of push lanes; 1 <= Lanes <= Size.
- T, logic, entry data type.
- Width, $clog2(Size), localparam; index width.

Ports:
- clk_ni  input  1  clock; all state updates on its falling edge.
- rst_i  input  1  synchronous active-high reset, sampled on the falling edge of clk_ni.
- flush_i  input  1  discard all current entries this cycle.
- push_i  input  [Lanes-1:0]  per-lane push request.
- data_i  input  T [Lanes-1:0]  per-lane push data.
- accept_o  output  [Lanes-1:0]  combinational; lane's push is taken at the coming falling edge.
- pop_i  input  [Size-1:0]  per-entry pop mask, indexed by current position.
- size_o  output  [Width:0]  number of valid entries.
- free_o  output  [Width:0]  Size - size_o.
- valid_o  output  [Size-1:0]  bit i = (i < size_o).
- empty_o  output  1  size_o == 0.
- full_o  output  1  size_o == Size.
- data_o  output  T [Size-1:0]  entry contents; index 0 is the oldest.

Behaviour:
- Reset (rst_i=1 at a falling edge): size_o=0, free_o=Size, valid_o=0, empty_o=1, full_o=0. data_o contents are not reset and are unspecified.
- accept_o is 0 while rst_i=1. Reset overrides flush, pop and push.
- Pop filtering: pop_i[i] counts only if i < size_o. Bits at or above size_o are ignored. Let P = number of effective pops.
- Slot reuse: available slots F = free_o + P, or Size when flush_i=1. Slots freed by this cycle's pops are usable in the same cycle.
- Acceptance: requesting lanes are taken in ascending lane index; the first min(F, popcount(push_i)) requesting lanes are accepted. accept_o[k] = push_i[k] && (number of requesting lanes below k) < F. Non-requesting lanes never consume a slot.
- Update at a falling edge, no flush:
  - Surviving entries (valid, not popped) move to indices 0..S-1, keeping their relative order (S = size_o - P).
  - Accepted lanes are written to indices S, S+1, ... in ascending lane order.
  - size_o <= S + number of accepted lanes.
- Flush (flush_i=1):
  - All current entries are discarded; pop_i is ignored.
  - Accepted pushes are written from index 0 in lane order; size_o <= number accepted.
- Latency: an accepted item is visible on data_o, and counted in size_o, right after the accepting falling edge. Pops take effect at the same edge.
- Status outputs (free_o, valid_o, empty_o, full_o) are pure functions of registered size_o; none depends combinationally on any input.
- Entries at index >= size_o hold unspecified values and must not be checked.
- Arithmetic: all counts are Width+1 bits; size_o never exceeds Size and never underflows.
- Full with no pops: all accept_o=0 and contents hold.
- Full with pops: exactly min(P, requesting lanes) pushes are accepted.
- Empty with a pop mask: the mask is ignored; pushes are accepted normally.
- Reset in the middle of traffic: the queue is empty after that edge; pushes presented in the reset cycle are lost.

Test Plan:
- Reset, then push_i=2'b11 with data 0xA,0xB -> accept_o=2'b11; after the edge size_o=2, data_o[0]=0xA, data_o[1]=0xB, valid_o=16'h0003.
- Fill to 16 entries 0..15, then pop_i=16'h0005 with no push -> size_o=14; data_o[0..2]=1,3,4 and order preserved through index 13 (=15).
- Full queue (0..15), pop_i=16'h8000, push_i=2'b11 data 0x20,0x21 -> accept_o=2'b01; after the edge size_o=16, data_o[15]=0x20, full_o=1.
- Size 5, flush_i=1, pop_i=16'h001F, push_i=2'b10 data1=0x33 -> accept_o=2'b10; after the edge size_o=1, data_o[0]=0x33.
- Size 3, pop_i=16'hFFF8 (only invalid bits set), push_i=0 -> size_o stays 3 and contents are unchanged.
- Size 7, rst_i=1 with push_i=2'b11 and pop_i=16'h0001 -> accept_o=0; after the edge size_o=0, empty_o=1, free_o=16.

Source files
------------

// File: rtl/multi_push_queue.sv
// Compacting multi-push queue.
// Up to Lanes items can be appended per cycle, and any subset of the valid
// entries can be retired per cycle through a per-entry pop mask. Surviving
// entries slide toward index 0 in their original order. New items are placed
// directly behind the survivors. All state changes on the falling edge of clk_ni.
module multi_push_queue #(
  parameter int  Size  = 16,
  parameter int  Lanes = 2,
  parameter type T     = logic,
  localparam int Width = $clog2(Size)
) (
  input  logic               clk_ni,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic [Lanes-1:0]   push_i,
  input  T     [Lanes-1:0]   data_i,
  output logic [Lanes-1:0]   accept_o,
  input  logic [Size-1:0]    pop_i,
  output logic [Width:0]     size_o,
  output logic [Width:0]     free_o,
  output logic [Size-1:0]    valid_o,
  output logic               empty_o,
  output logic               full_o,
  output T     [Size-1:0]    data_o
);

  logic [Width:0]   size_q;
  T     [Size-1:0]  data_q;

  logic [Size-1:0]  valid_mask;
  logic [Size-1:0]  eff_pop;
  logic [Width:0]   pop_count;
  logic [Width:0]   slots;
  logic [Lanes-1:0] accept;
  logic [Width:0]   req_below;
  logic [Width:0]   wr_ptr;
  logic [Width:0]   size_next;
  T     [Size-1:0]  data_next;

  // Thermometer mask of occupied slots, derived only from the registered size.
  always_comb begin
    valid_mask = '0;
    for (int i = 0; i < Size; i++) begin
      valid_mask[i] = ((Width+1)'(i) < size_q);
    end
  end

  // Pops aimed at empty slots are ignored.
  assign eff_pop = pop_i & valid_mask;

  // Count effective pops; slots freed this cycle can be refilled right away.
  always_comb begin
    pop_count = '0;
    for (int i = 0; i < Size; i++) begin
      pop_count = pop_count + (Width+1)'(eff_pop[i]);
    end
    slots = flush_i ? (Width+1)'(Size) : (free_o + pop_count);
  end

  // Grant requesting lanes in ascending order until the available slots run out.
  always_comb begin
    accept    = '0;
    req_below = '0;
    for (int k = 0; k < Lanes; k++) begin
      if (push_i[k]) begin
        if (!rst_i && (req_below < slots)) begin
          accept[k] = 1'b1;
        end
        req_below = req_below + 1'b1;
      end
    end
  end

  // Compact the survivors to the front, then append granted lanes behind them.
  always_comb begin
    data_next = data_q;
    wr_ptr    = '0;
    if (!flush_i) begin
      for (int i = 0; i < Size; i++) begin
        if (valid_mask[i] && !pop_i[i]) begin
          data_next[wr_ptr[Width-1:0]] = data_q[i];
          wr_ptr = wr_ptr + 1'b1;
        end
      end
    end
    for (int k = 0; k < Lanes; k++) begin
      if (accept[k]) begin
        data_next[wr_ptr[Width-1:0]] = data_i[k];
        wr_ptr = wr_ptr + 1'b1;
      end
    end
    size_next = wr_ptr;
  end

  // Falling-edge state update; reset empties the queue but leaves the contents alone.
  always_ff @(negedge clk_ni) begin
    if (rst_i) begin
      size_q <= '0;
    end else begin
      size_q <= size_next;
      data_q <= data_next;
    end
  end

  assign accept_o = accept;
  assign size_o   = size_q;
  assign free_o   = (Width+1)'(Size) - size_q;
  assign valid_o  = valid_mask;
  assign empty_o  = (size_q == '0);
  assign full_o   = (size_q == (Width+1)'(Size));
  assign data_o   = data_q;

endmodule
